// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the tri-state bus arbiter family.
// Holds the FSM state encoding and the round-robin search.
// The search is reusable by any arbiter with up to RR_MAX requesters.
package tristate_bus_arbiter_pkg;

    // FSM state encoding, kept as plain constants for legacy tools.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    // Widest request vector the round-robin helper accepts.
    localparam int RR_MAX = 32;
    localparam int RR_IW  = $clog2(RR_MAX);

    // Round-robin pick: first set bit of req_vec found by searching
    // last+1, last+2, ... modulo n. The search wraps all the way back
    // to 'last' itself, so a sole requester can win again.
    // Returns 'last' when no bit is set; callers gate on |req anyway.
    function automatic int unsigned rr_next(
        input logic [RR_MAX-1:0] req_vec,
        input int unsigned       last,
        input int unsigned       n
    );
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            idx = (last + k) % n;
            if (k <= n && !found && req_vec[idx[RR_IW-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_tri_driver.sv
// Per-channel tri-state driver onto the shared bus.
// One bufif1 per bit; the output floats whenever en is low.
module tri_driver #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output wire  [WIDTH-1:0] y
);

    // One tri-state primitive per data bit, all sharing the same enable.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        bufif1 u_buf (y[b], d[b], en);
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for N_CH channels sharing one tri-state bus.
// A channel owns the bus for at most MAX_BURST cycles, then the bus
// floats for TURN_CYC turnaround cycles plus one arbitration cycle
// before the next owner may drive, so drivers never overlap.
//
// Request/grant handshake: req[k] is a level request held by channel k
// for as long as it wants the bus. grant[k] is registered and goes high
// on the edge after channel k wins arbitration in IDLE; channel k's data
// is on the bus for every cycle grant[k] is high. The grant ends when
// req[k] is seen low at an edge or the burst limit is reached, whichever
// comes first. Requests are only looked at in IDLE (for arbitration) and
// by the current owner (to end its burst early).
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH*WIDTH-1:0]   din,
    output wire  [WIDTH-1:0]        bus,
    output logic [N_CH-1:0]         grant,
    output logic [$clog2(N_CH)-1:0] owner,
    output logic                    busy,
    output logic [1:0]              state_dbg
);

    localparam int OW = $clog2(N_CH);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    localparam logic [BW-1:0]   BURST_LIM  = BW'(MAX_BURST);
    localparam logic [TW-1:0]   TURN_LIM   = TW'(TURN_CYC);
    localparam logic [OW-1:0]   RST_OWNER  = OW'(N_CH - 1);
    localparam logic [N_CH-1:0] ONE_HOT_LSB = N_CH'(1);

    logic [1:0]        state;
    logic [BW-1:0]     burst_cnt;
    logic [TW-1:0]     turn_cnt;
    logic [RR_MAX-1:0] req_ext;
    logic [OW-1:0]     winner;
    logic [N_CH-1:0]   win_onehot;
    logic              burst_end;

    // Round-robin winner among current requests, starting after the last owner.
    always_comb begin
        req_ext    = RR_MAX'(req);
        winner     = OW'(rr_next(req_ext, 32'(owner), N_CH));
        win_onehot = ONE_HOT_LSB << winner;
    end

    // A burst ends when the owner lets go or uses up its cycle allowance;
    // both together still count as a single exit to TURN.
    always_comb begin
        burst_end = !req[owner] || (burst_cnt == BURST_LIM);
    end

    // Arbitration FSM, grant register and burst/turnaround counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= RST_OWNER;
            burst_cnt <= '0;
            turn_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= DRIVE;
                        grant     <= win_onehot;
                        owner     <= winner;
                        burst_cnt <= BW'(1);
                    end
                end
                DRIVE: begin
                    if (burst_end) begin
                        state    <= TURN;
                        grant    <= '0;
                        turn_cnt <= TW'(1);
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LIM) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        busy      = (state == DRIVE) || (state == TURN);
        state_dbg = state;
    end

    // Drive enables come straight from the registered grant, so the bus
    // never glitches in response to req; at most one enable is ever high.
    for (genvar k = 0; k < N_CH; k++) begin : g_drv
        tri_driver #(.WIDTH(WIDTH)) u_drv (
            .en (grant[k]),
            .d  (din[k*WIDTH +: WIDTH]),
            .y  (bus)
        );
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter (N_CH=4, WIDTH=8, MAX_BURST=4, TURN_CYC=1).
// The bus net is pulled up, so a released bus reads 8'hFF; channel data
// used here never equals 8'hFF so a stray driver is always visible.
// Observed tuple: {grant[3:0], owner[1:0], busy, state[1:0], bus[7:0]}.
module tb_tristate_bus_arbiter;

  localparam int N_CH      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int TURN_CYC  = 1;
  localparam logic [7:0] FLOAT = 8'hFF;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       req;
  logic [N_CH*WIDTH-1:0] din;
  tri1  [WIDTH-1:0]      bus;
  logic [N_CH-1:0]       grant;
  logic [1:0]            owner;
  logic                  busy;
  logic [1:0]            state_dbg;
  logic [16:0]           act;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(
    .N_CH(N_CH), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .bus(bus),
    .grant(grant), .owner(owner), .busy(busy), .state_dbg(state_dbg)
  );

  assign act = {grant, owner, busy, state_dbg, bus};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Owner-centric view: who holds the bus and for how long, how many
  // floating turnaround cycles remain, and who owned it last.
  int m_own  = -1;
  int m_last = N_CH - 1;
  int m_len  = 0;
  int m_gap  = 0;

  logic [16:0] exp_q[$];

  function automatic void model_step();
    if (rst) begin
      m_own  = -1;
      m_last = N_CH - 1;
      m_len  = 0;
      m_gap  = 0;
    end else if (m_own >= 0) begin
      if (!req[m_own] || m_len == MAX_BURST) begin
        m_own = -1;
        m_gap = TURN_CYC;
      end else begin
        m_len++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != '0) begin
      for (int k = 1; k <= N_CH; k++) begin
        if (m_own < 0 && req[(m_last + k) % N_CH]) m_own = (m_last + k) % N_CH;
      end
      m_last = m_own;
      m_len  = 1;
    end
  endfunction

  function automatic logic [16:0] model_exp();
    logic [3:0] g;
    if (m_own >= 0) begin
      g = 4'd1 << m_own;
      return {g, 2'(m_last), 1'b1, 2'd1, din[m_own*WIDTH +: WIDTH]};
    end else if (m_gap > 0) begin
      return {4'b0000, 2'(m_last), 1'b1, 2'd2, FLOAT};
    end
    return {4'b0000, 2'(m_last), 1'b0, 2'd0, FLOAT};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: inputs already set, model sees the same values as the DUT,
  // outputs are then sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [16:0] e;
    rst = 1'b1;
    req = 4'b1111;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 2; i++) begin
      cycle();
      e = {4'b0000, 2'd3, 1'b0, 2'd0, FLOAT};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d got=%h expected=%h", i, act, e);
      end
    end
    rst = 1'b0;
    cycle();
    e = {4'b0001, 2'd0, 1'b1, 2'd1, 8'h11};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL first_grant got=%h expected=%h", act, e);
    end
  endtask

  task automatic test_single();
    logic [16:0] e [4];
    do_reset();
    din = {8'h44, 8'h33, 8'hA5, 8'h11};
    e[0] = {4'b0010, 2'd1, 1'b1, 2'd1, 8'hA5};
    e[1] = {4'b0010, 2'd1, 1'b1, 2'd1, 8'hA5};
    e[2] = {4'b0000, 2'd1, 1'b1, 2'd2, FLOAT};
    e[3] = {4'b0000, 2'd1, 1'b0, 2'd0, FLOAT};
    for (int i = 0; i < 4; i++) begin
      req = (i < 2) ? 4'b0010 : 4'b0000;
      cycle();
      n_checks++;
      if (act !== e[i]) begin
        n_fail++;
        $display("FAIL single_req cyc=%0d got=%h expected=%h", i, act, e[i]);
      end
    end
  endtask

  // Round-robin rotation with all channels requesting.
  task automatic test_round_robin();
    logic [16:0] e;
    logic [3:0]  g;
    int          ch;
    do_reset();
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      ch = r % N_CH;
      g  = 4'd1 << ch;
      for (int c = 0; c < 6; c++) begin
        cycle();
        if (c < 4)       e = {g, 2'(ch), 1'b1, 2'd1, din[ch*WIDTH +: WIDTH]};
        else if (c == 4) e = {4'b0000, 2'(ch), 1'b1, 2'd2, FLOAT};
        else             e = {4'b0000, 2'(ch), 1'b0, 2'd0, FLOAT};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL round_robin grant=%0d cyc=%0d got=%h expected=%h", r, c, act, e);
        end
      end
    end
    req = '0;
  endtask

  // A lone requester hits the burst limit, yields, and is re-granted.
  task automatic test_sole_requester();
    logic [16:0] e;
    do_reset();
    din = {8'h44, 8'h33, 8'h22, 8'h5A};
    req = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if ((i % 6) < 4)       e = {4'b0001, 2'd0, 1'b1, 2'd1, 8'h5A};
      else if ((i % 6) == 4) e = {4'b0000, 2'd0, 1'b1, 2'd2, FLOAT};
      else                   e = {4'b0000, 2'd0, 1'b0, 2'd0, FLOAT};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL sole_req cyc=%0d got=%h expected=%h", i, act, e);
      end
    end
    req = '0;
  endtask

  // Reset in the third drive cycle of channel 2 abandons the burst.
  task automatic test_reset_mid_burst();
    logic [16:0] e;
    do_reset();
    din = {8'h44, 8'h3C, 8'h22, 8'h11};
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      e = {4'b0100, 2'd2, 1'b1, 2'd1, 8'h3C};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL mid_reset_drive cyc=%0d got=%h expected=%h", i, act, e);
      end
    end
    rst = 1'b1;
    req = 4'b0101;
    cycle();
    e = {4'b0000, 2'd3, 1'b0, 2'd0, FLOAT};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL mid_reset_clear got=%h expected=%h", act, e);
    end
    rst = 1'b0;
    cycle();
    e = {4'b0001, 2'd0, 1'b1, 2'd1, 8'h11};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL mid_reset_regrant got=%h expected=%h", act, e);
    end
    req = '0;
  endtask

  // Random requests, data and occasional resets against the model.
  task automatic test_random();
    logic [16:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int k = 0; k < N_CH; k++) din[k*WIDTH +: WIDTH] = 8'($urandom_range(0, 254));
      cycle();
      exp_q.push_back(model_exp());
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL random cyc=%0d req=%b got=%h expected=%h", i, req, act, e);
      end
      n_checks++;
      if (!$onehot0(grant)) begin
        n_fail++;
        $display("FAIL grant_onehot cyc=%0d got=%b expected=onehot_or_zero", i, grant);
      end
    end
    rst = 1'b0;
    req = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    req = '0;
    din = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_sole_requester();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
